// File: rtl/jkff_pkg.sv
// Shared JK command encoding and next-state rule for the jkff bank.
package jkff_pkg;

  // Commands are ordered {j,k} so a cell can cast its two inputs directly.
  typedef enum logic [1:0] {
    JK_HOLD = 2'b00,
    JK_CLR  = 2'b01,
    JK_SET  = 2'b10,
    JK_TGL  = 2'b11
  } jk_cmd_e;

  function automatic logic next_q(input jk_cmd_e cmd, input logic q);
    logic nq;
    nq = q;
    case (cmd)
      JK_HOLD: nq = q;
      JK_CLR:  nq = 1'b0;
      JK_SET:  nq = 1'b1;
      JK_TGL:  nq = ~q;
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/jkff_cell.sv
// Single-bit JK flip-flop with synchronous active-high reset and complement output.
module jkff_cell
  import jkff_pkg::*;
#(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q1,
  output logic q2
);

  jk_cmd_e cmd;

  assign cmd = jk_cmd_e'({j, k});

  // NOTE: state registers use non-blocking assignment so every cell samples
  // the pre-edge value of q1 regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      q1 <= RESET_VALUE;
    end else begin
      q1 <= next_q(cmd, q1);
    end
  end

  // Derived from the register so q2 can never disagree with q1.
  assign q2 = ~q1;

endmodule

// File: rtl/jkff.sv
// Bank of WIDTH independent JK flip-flops sharing one clock and reset.
module jkff
  import jkff_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jkff_cell #(
      .RESET_VALUE(RESET_VALUE[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .j  (j[i]),
      .k  (k[i]),
      .q1 (q1[i]),
      .q2 (q2[i])
    );
  end

endmodule

// File: tb/tb_jkff.sv
// Self-checking bench: single-bit vector table, wide-bank sequence, random vs model.
module tb_jkff;

  logic clk = 1'b0;
  always #25 clk = ~clk;

  // Single-bit instance with default parameters.
  logic n_rst, n_j, n_k, n_q1, n_q2;
  jkff u_narrow (
    .clk(clk), .rst(n_rst), .j(n_j), .k(n_k), .q1(n_q1), .q2(n_q2)
  );

  // Wide instance.
  localparam logic [3:0] W_RV = 4'b1010;
  logic       w_rst;
  logic [3:0] w_j, w_k, w_q1, w_q2;
  jkff #(.WIDTH(4), .RESET_VALUE(W_RV)) u_wide (
    .clk(clk), .rst(w_rst), .j(w_j), .k(w_k), .q1(w_q1), .q2(w_q2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: characteristic rule Q+ = J&~Q | ~K&Q, reset wins.
  function automatic logic [3:0] model_next(input logic [3:0] q, input logic r,
                                            input logic [3:0] jj, input logic [3:0] kk,
                                            input logic [3:0] rv);
    return r ? rv : ((jj & ~q) | (~kk & q));
  endfunction

  typedef struct {
    logic rst;
    logic j;
    logic k;
    logic exp_q;
  } vec_t;

  vec_t vecs[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] m;
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] m;
    logic [3:0] e;

    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0}; // reset with j=k=1
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1}; // set
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0}; // clear
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1}; // toggle x4
    vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1}; // set, then hold x4
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1}; // idempotent set
    vecs[16] = '{1'b1, 1'b1, 1'b1, 1'b0}; // reset mid-toggle
    vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b1}; // resume from reset value

    n_rst = 1'b1; n_j = 1'b0; n_k = 1'b0;
    w_rst = 1'b1; w_j = 4'b0; w_k = 4'b0;

    // Table-driven single-bit vectors.
    for (int i = 0; i < 18; i++) begin
      n_rst = vecs[i].rst;
      n_j   = vecs[i].j;
      n_k   = vecs[i].k;
      tick();
      check($sformatf("vec%0d_q1", i), {3'b0, n_q1}, {3'b0, vecs[i].exp_q});
      check($sformatf("vec%0d_q2", i), {3'b0, n_q2}, {3'b0, ~vecs[i].exp_q});
    end

    // Inputs that change between edges must neither reach the outputs nor be captured.
    n_rst = 1'b0; n_j = 1'b0; n_k = 1'b1;
    tick();
    check("pre_glitch_q1", {3'b0, n_q1}, 4'b0000);
    #10; n_j = 1'b1; n_k = 1'b0;
    #1;
    check("no_comb_path_q1", {3'b0, n_q1}, 4'b0000);
    #5; n_j = 1'b0; n_k = 1'b0;
    tick();
    check("glitch_ignored_q1", {3'b0, n_q1}, 4'b0000);

    // Wide bank: reset to 1010, then hold/clear/set/toggle on separate bits.
    w_rst = 1'b1; w_j = 4'b1111; w_k = 4'b0000;
    tick();
    check("wide_rst_q1", w_q1, 4'b1010);
    check("wide_rst_q2", w_q2, 4'b0101);
    m = W_RV;
    w_rst = 1'b0; w_j = 4'b0011; w_k = 4'b0101;
    tick();
    check("wide_mix1_q1", w_q1, 4'b1011);
    check("wide_mix1_q2", w_q2, 4'b0100);
    tick();
    check("wide_mix2_q1", w_q1, 4'b1010);
    check("wide_mix2_q2", w_q2, 4'b0101);
    m = 4'b1010;

    // Randomized stimulus against the reference rule.
    for (int i = 0; i < 300; i++) begin
      w_rst = ($urandom_range(15) == 0);
      w_j   = 4'($urandom);
      w_k   = 4'($urandom);
      e     = model_next(m, w_rst, w_j, w_k, W_RV);
      tick();
      check($sformatf("rand%0d_q1", i), w_q1, e);
      check($sformatf("rand%0d_q2", i), w_q2, ~e);
      m = e;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
